serial_add_ctrl: RTL

- Bit-serial adder controller: sequences a single 1-bit adder cell, built from two half-adder stages, over WIDTH cycles to add two WIDTH-bit operands.
- Trades area for latency.
- Sits between a host issuing START/operands and a result consumer waiting on a DONE pulse.
- Lab-level building block for the arithmetic unit.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_fa_cell.sv | 18 +
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and default width for the bit-serial adder.
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SERIAL_ADD_W = 8;

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder from two half-adder stages and a carry OR.
module serial_fa_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   logic p, g, pc;

   assign p   = a_i ^ b_i;
   assign g   = a_i & b_i;
   assign s_o = p ^ c_i;
   assign pc  = p & c_i;
   assign c_o = g | pc;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, one operand bit per cycle through one full-adder cell.
// Defining SERIAL_ADD_SUB_EN adds the SUB port (A-B via inverted B and carry-in forced to 1).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADD_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             SUB,
`endif
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d;
   logic               c_q, c_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-2:0]   r_q, r_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic [WIDTH-1:0]   b_in, sh;
   logic               c_in, s, co, last;

`ifdef SERIAL_ADD_SUB_EN
   assign b_in = SUB ? ~B : B;
   assign c_in = SUB ? 1'b1 : CIN;
`else
   assign b_in = B;
   assign c_in = CIN;
`endif

   serial_fa_cell u_fa (
      .a_i (sa_q[0]),
      .b_i (sb_q[0]),
      .c_i (c_q),
      .s_o (s),
      .c_o (co)
   );

   // r_q only needs WIDTH-1 bits: the final sum bit goes straight into SUM
   assign sh   = {s, r_q};
   assign last = cnt_q == CNT_W'(WIDTH - 1);

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               sa_d    = A;
               sb_d    = b_in;
               c_d     = c_in;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            c_d   = co;
            r_d   = sh[WIDTH-1:1];
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
               sum_d   = sh;
               cout_d  = co;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         r_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign BUSY = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign DONE = state_q == ST_DONE;
   assign SUM  = sum_q;
   assign COUT = cout_q;

endmodule
